// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the cache controller and the SRAM controller.
// The slave modport is the cache's view. The master modport is the view of its surroundings.
interface cache_controller_if;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_read_en;
   logic        sram_write_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   modport slave (
      input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      output rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      input  rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
   );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete in the request cycle. Misses and writes stall on the SRAM controller.
module cache_controller #(
   parameter int TAG_W   = 10,
   parameter int INDEX_W = 6
) (
   input logic               clk,
   input logic               rst,
   cache_controller_if.slave bus
);
   localparam int SETS = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_e;

   state_e state_q, state_d;

   logic [1:0][SETS-1:0] valid_q;
   logic [SETS-1:0]      lru_q;
   logic [TAG_W-1:0]     tag_q  [2][SETS];
   logic [63:0]          data_q [2][SETS];

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               word_sel;
   logic               hit0, hit1, hit, hit_way, victim;
   logic [63:0]        hit_line;
   logic               fill_en, rd_hit_en, wr_hit_en;

   assign idx      = bus.address[3 +: INDEX_W];
   assign tag      = bus.address[3 + INDEX_W +: TAG_W];
   assign word_sel = bus.address[2];
   assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
   assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
   assign hit      = hit0 | hit1;
   assign hit_way  = hit1;
   assign hit_line = data_q[hit_way][idx];
   // An invalid way is filled first, with way 0 preferred. Otherwise the LRU way is replaced.
   assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

   always_comb begin
      state_d           = state_q;
      bus.ready         = 1'b0;
      bus.rdata         = '0;
      bus.sram_address  = '0;
      bus.sram_wdata    = '0;
      bus.sram_read_en  = 1'b0;
      bus.sram_write_en = 1'b0;
      fill_en           = 1'b0;
      rd_hit_en         = 1'b0;
      wr_hit_en         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.MEM_W_EN) begin
               state_d   = WRITE;
               wr_hit_en = hit;
            end else if (bus.MEM_R_EN) begin
               if (hit) begin
                  bus.ready = 1'b1;
                  bus.rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
                  rd_hit_en = 1'b1;
               end else begin
                  state_d = READ_MISS;
               end
            end else begin
               bus.ready = 1'b1;
            end
         end
         READ_MISS: begin
            bus.sram_read_en = 1'b1;
            bus.sram_address = {bus.address[31:3], 3'b000};
            if (bus.sram_ready) begin
               bus.ready = 1'b1;
               bus.rdata = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
               fill_en   = 1'b1;
               state_d   = IDLE;
            end
         end
         WRITE: begin
            bus.sram_write_en = 1'b1;
            bus.sram_address  = bus.address;
            bus.sram_wdata    = bus.wdata;
            if (bus.sram_ready) begin
               bus.ready = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         if (fill_en) begin
            valid_q[victim][idx] <= 1'b1;
            lru_q[idx]           <= ~victim;
         end else if (rd_hit_en || wr_hit_en) begin
            lru_q[idx] <= ~hit_way;
         end
      end
   end

   // Tags and data need no reset; the valid bits gate their use.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[victim][idx]  <= tag;
         data_q[victim][idx] <= bus.sram_rdata;
      end else if (wr_hit_en) begin
         if (word_sel) data_q[hit_way][idx][63:32] <= bus.wdata;
         else          data_q[hit_way][idx][31:0]  <= bus.wdata;
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vectors, multi-cycle corner sequences and random traffic.
// The reference model is a backing memory plus a per-set list of resident line tags, most recent first.
module tb_cache_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_controller_if bus ();

   cache_controller #(.TAG_W(10), .INDEX_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [int unsigned];
   int unsigned lines [64][$];

   typedef struct {
      bit          r;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      int          lat;
      bit          hit;
      logic [31:0] rd;
   } vec_t;

   vec_t vt [16];

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      if (mem.exists(int'(a[31:2]))) return mem[int'(a[31:2])];
      return 32'hA000_0000 | {a[31:2], 2'b00};
   endfunction

   function automatic void mem_wr(logic [31:0] a, logic [31:0] d);
      mem[int'(a[31:2])] = d;
   endfunction

   function automatic bit model_hit(logic [31:0] a);
      int unsigned s = int'(a[8:3]);
      int unsigned t = int'(a[18:9]);
      for (int i = 0; i < lines[s].size(); i++)
         if (lines[s][i] == t) return 1'b1;
      return 1'b0;
   endfunction

   // A resident line becomes most recent. A missing line is added only when alloc is set.
   // Adding a line to a full set drops the least recent one.
   function automatic void model_use(logic [31:0] a, bit alloc);
      int unsigned s = int'(a[8:3]);
      int unsigned t = int'(a[18:9]);
      int pos = -1;
      for (int i = 0; i < lines[s].size(); i++)
         if (lines[s][i] == t) pos = i;
      if (pos >= 0) begin
         lines[s].delete(pos);
         lines[s].push_front(t);
      end else if (alloc) begin
         if (lines[s].size() >= 2) void'(lines[s].pop_back());
         lines[s].push_front(t);
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 64; s++) lines[s].delete();
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
      bus.address  = '0;
      bus.wdata    = '0;
      bus.sram_ready = 1'b0;
   endtask

   // One complete access. The SRAM completes after lat cycles of enable. The model is updated at the end.
   task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input bit exp_hit, input logic [31:0] exp_rd,
                         input string nm);
      bit          path_read = r && !w;
      int          en_cycles = 0;
      logic [31:0] line = {a[31:3], 3'b000};
      bus.MEM_R_EN   = r;
      bus.MEM_W_EN   = w;
      bus.address    = a;
      bus.wdata      = d;
      bus.sram_ready = 1'b0;
      bus.sram_rdata = {mem_rd(line | 32'h4), mem_rd(line)};
      @(negedge clk);
      if (path_read && exp_hit) begin
         check({nm, " hit ready"}, 64'(bus.ready), 64'd1);
         check({nm, " hit rdata"}, 64'(bus.rdata), 64'(exp_rd));
         check({nm, " hit no sram"}, 64'({bus.sram_read_en, bus.sram_write_en}), 64'd0);
         @(posedge clk); #1;
         idle_inputs();
         model_use(a, 1'b1);
         return;
      end
      check({nm, " request ready low"}, 64'(bus.ready), 64'd0);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         bus.sram_ready = (k == lat);
         @(negedge clk);
         if (bus.sram_read_en || bus.sram_write_en) en_cycles++;
         check({nm, " sram enables"}, 64'({bus.sram_read_en, bus.sram_write_en}),
               path_read ? 64'd2 : 64'd1);
         check({nm, " sram_address"}, 64'(bus.sram_address), path_read ? 64'(line) : 64'(a));
         if (!path_read) check({nm, " sram_wdata"}, 64'(bus.sram_wdata), 64'(d));
         check({nm, " ready"}, 64'(bus.ready), 64'(k == lat));
         if (path_read && k == lat) check({nm, " miss rdata"}, 64'(bus.rdata), 64'(exp_rd));
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check({nm, " enables dropped"}, 64'({bus.sram_read_en, bus.sram_write_en}), 64'd0);
      check({nm, " idle ready"}, 64'(bus.ready), 64'd1);
      check({nm, " enable cycles"}, 64'(en_cycles), 64'(lat));
      if (path_read) model_use(a, 1'b1);
      else begin
         model_use(a, 1'b0);
         mem_wr(a, d);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          kind;
      bit          r;
      bit          w;
      int          lat;

      rst = 1'b1;
      idle_inputs();
      bus.sram_rdata = '0;
      model_reset();
      mem_wr(32'h100, 32'h1111_1111);
      mem_wr(32'h104, 32'h2222_2222);

      vt[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,         4, 1'b0, 32'h1111_1111};
      vt[1]  = '{1'b1, 1'b0, 32'h104, 32'h0,         1, 1'b1, 32'h2222_2222};
      vt[2]  = '{1'b1, 1'b0, 32'h000, 32'h0,         2, 1'b0, 32'hA000_0000};
      vt[3]  = '{1'b1, 1'b0, 32'h200, 32'h0,         3, 1'b0, 32'hA000_0200};
      vt[4]  = '{1'b1, 1'b0, 32'h000, 32'h0,         1, 1'b1, 32'hA000_0000};
      vt[5]  = '{1'b1, 1'b0, 32'h400, 32'h0,         1, 1'b0, 32'hA000_0400};
      vt[6]  = '{1'b1, 1'b0, 32'h000, 32'h0,         1, 1'b1, 32'hA000_0000};
      vt[7]  = '{1'b1, 1'b0, 32'h200, 32'h0,         2, 1'b0, 32'hA000_0200};
      vt[8]  = '{1'b1, 1'b0, 32'h000, 32'h0,         1, 1'b1, 32'hA000_0000};
      vt[9]  = '{1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 3, 1'b0, 32'h0};
      vt[10] = '{1'b1, 1'b0, 32'h104, 32'h0,         1, 1'b1, 32'hDEAD_BEEF};
      vt[11] = '{1'b0, 1'b1, 32'h300, 32'h1234_5678, 2, 1'b0, 32'h0};
      vt[12] = '{1'b1, 1'b0, 32'h300, 32'h0,         2, 1'b0, 32'h1234_5678};
      vt[13] = '{1'b1, 1'b1, 32'h108, 32'h5555_5555, 2, 1'b0, 32'h0};
      vt[14] = '{1'b1, 1'b0, 32'h108, 32'h0,         1, 1'b0, 32'h5555_5555};
      vt[15] = '{1'b1, 1'b0, 32'h104, 32'h0,         1, 1'b1, 32'hDEAD_BEEF};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset enables", 64'({bus.sram_read_en, bus.sram_write_en}), 64'd0);
      check("reset sram_address", 64'(bus.sram_address), 64'd0);
      check("reset sram_wdata", 64'(bus.sram_wdata), 64'd0);
      check("reset rdata", 64'(bus.rdata), 64'd0);
      check("reset ready", 64'(bus.ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++)
         access(vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].lat, vt[i].hit, vt[i].rd,
                $sformatf("vec%0d", i));

      // A stray sram_ready in IDLE must be ignored.
      @(posedge clk); #1;
      bus.sram_ready = 1'b1;
      @(negedge clk);
      check("stray sram_ready ready", 64'(bus.ready), 64'd1);
      check("stray sram_ready enables", 64'({bus.sram_read_en, bus.sram_write_en}), 64'd0);
      @(posedge clk); #1;
      bus.sram_ready = 1'b0;
      access(1'b1, 1'b0, 32'h104, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, "after stray");

      // Reset arrives in the middle of a read miss.
      bus.MEM_R_EN   = 1'b1;
      bus.address    = 32'h600;
      bus.sram_rdata = {mem_rd(32'h604), mem_rd(32'h600)};
      @(negedge clk);
      check("abort request ready", 64'(bus.ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort read_en up", 64'(bus.sram_read_en), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("abort read_en dropped", 64'(bus.sram_read_en), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      model_reset();
      access(1'b1, 1'b0, 32'h600, 32'h0, 2, 1'b0, mem_rd(32'h600), "post-abort 0x600");
      access(1'b1, 1'b0, 32'h104, 32'h0, 1, 1'b0, mem_rd(32'h104), "post-abort 0x104");

      for (int n = 0; n < 400; n++) begin
         a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3) |
             (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
         d    = $urandom;
         kind = int'($urandom_range(0, 9));
         r    = (kind < 7);
         w    = (kind >= 6);
         lat  = int'($urandom_range(1, 4));
         access(r, w, a, d, lat, model_hit(a), mem_rd(a), $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
